// File: rtl/vcache_req_arbiter.sv
// vcache_req_arbiter: round-robin arbiter sharing one vcache request port among
// num_req_p requesters. A tag FIFO of requester IDs routes the in-order
// responses back to the requester that issued each request.
// Optional statistics counters are built when VCACHE_ARB_STATS_EN is defined.
module vcache_req_arbiter #(
  parameter int num_req_p    = 2,
  parameter int pkt_width_p  = 32,
  parameter int data_width_p = 32,
  parameter int max_out_p    = 4,
  localparam int id_width_lp  = $clog2(num_req_p),
  localparam int cnt_width_lp = $clog2(max_out_p + 1),
  localparam int ptr_width_lp = (max_out_p > 1) ? $clog2(max_out_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [num_req_p-1:0]           req_v_i,
  input  logic [num_req_p*pkt_width_p-1:0] req_pkt_i,
  output logic [num_req_p-1:0]           req_ready_o,
  output logic                           cache_v_o,
  output logic [pkt_width_p-1:0]         cache_pkt_o,
  input  logic                           cache_ready_i,
  input  logic                           cache_v_i,
  input  logic [data_width_p-1:0]        cache_data_i,
  output logic                           cache_yumi_o,
  output logic [num_req_p-1:0]           resp_v_o,
  output logic [data_width_p-1:0]        resp_data_o,
  input  logic [num_req_p-1:0]           resp_yumi_i,
  output logic [cnt_width_lp-1:0]        outstanding_o,
  output logic                           error_o,
  output logic [31:0]                    grant_total_o,
  output logic [31:0]                    stall_cycles_o
);

  logic [id_width_lp-1:0]  rr_q, rr_d, grant_s, head_s;
  logic                    any_v_s, full_s, empty_s, cache_v_s, push_s, pop_s;
  logic [ptr_width_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic                    error_q, error_d;
  logic [num_req_p-1:0]    resp_v_s, req_ready_s;
  logic [id_width_lp-1:0]  tag_q [max_out_p];

  // Circular pointer increment that wraps at the FIFO depth (depth need not be a power of two).
  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    if (p == ptr_width_lp'(max_out_p - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + 1'b1;
    end
  endfunction

  // Round-robin search: first valid requester at or above rr_q, modulo num_req_p.
  always_comb begin : grant_search
    int idx;
    grant_s = '0;
    any_v_s = 1'b0;
    idx     = 0;
    // Walk offsets from highest to lowest so the smallest offset wins last.
    for (int k = num_req_p - 1; k >= 0; k--) begin
      idx = (int'(rr_q) + k) % num_req_p;
      if (req_v_i[id_width_lp'(idx)]) begin
        grant_s = id_width_lp'(idx);
        any_v_s = 1'b1;
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // Request path: full flag is registered, so cache_ready_i never reaches cache_v_o.
  always_comb begin
    full_s    = (cnt_q == cnt_width_lp'(max_out_p));
    cache_v_s = any_v_s & ~full_s;
    push_s    = cache_v_s & cache_ready_i;
    for (int i = 0; i < num_req_p; i++) begin
      req_ready_s[i] = push_s & (grant_s == id_width_lp'(i));
    end
    cache_pkt_o = req_pkt_i[int'(grant_s)*pkt_width_p +: pkt_width_p];
  end

  // Response path: route to the FIFO head; stray responses or yumis flag an error.
  always_comb begin
    empty_s = (cnt_q == '0);
    head_s  = tag_q[rptr_q];
    for (int i = 0; i < num_req_p; i++) begin
      resp_v_s[i] = cache_v_i & ~empty_s & (head_s == id_width_lp'(i));
    end
    pop_s   = |(resp_v_s & resp_yumi_i);
    error_d = error_q | (cache_v_i & empty_s) | (|(resp_yumi_i & ~resp_v_s));
  end

  // Next-state for the priority pointer, FIFO pointers and occupancy.
  always_comb begin
    if (push_s) begin
      if (grant_s == id_width_lp'(num_req_p - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = grant_s + 1'b1;
      end
      wptr_d = ptr_inc(wptr_q);
    end else begin
      rr_d   = rr_q;
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = ptr_inc(rptr_q);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers, including the tag storage written on every accept.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
      for (int i = 0; i < max_out_p; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      rr_q    <= rr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      if (push_s) begin
        tag_q[wptr_q] <= grant_s;
      end
    end
  end

`ifdef VCACHE_ARB_STATS_EN
  logic [31:0] grant_cnt_q, grant_cnt_d, stall_cnt_q, stall_cnt_d;

  // Statistics: accepts and cycles stalled by the vcache; both wrap naturally.
  always_comb begin
    if (push_s) begin
      grant_cnt_d = grant_cnt_q + 32'd1;
    end else begin
      grant_cnt_d = grant_cnt_q;
    end
    if (cache_v_s & ~cache_ready_i) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      grant_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_total_o  = grant_cnt_q;
  assign stall_cycles_o = stall_cnt_q;
`else
  assign grant_total_o  = 32'd0;
  assign stall_cycles_o = 32'd0;
`endif

  assign cache_v_o     = cache_v_s;
  assign req_ready_o   = req_ready_s;
  assign resp_v_o      = resp_v_s;
  assign resp_data_o   = cache_data_i;
  assign cache_yumi_o  = pop_s;
  assign outstanding_o = cnt_q;
  assign error_o       = error_q;

endmodule
